// File: rtl/solver_scheduler_if.sv
// Job/result handshake bundle between a job source/result sink and solver_scheduler.
// Latency: none (wires only).
// Backpressure: job_ready stalls the source; result_ready stalls the scheduler's result register.
//
// Ports (signals):
//   job_valid/job_tag/job_ready             tagged job offer, accepted on valid&ready
//   result_valid/result_tag/result_count    finished job, taken on valid&result_ready
interface solver_scheduler_if #(
    parameter int TAG_BITS = 16
);
    logic                job_valid;
    logic [TAG_BITS-1:0] job_tag;
    logic                job_ready;
    logic                result_valid;
    logic                result_ready;
    logic [TAG_BITS-1:0] result_tag;
    logic [15:0]         result_count;

    // master: job producer / result consumer
    modport master (
        output job_valid, job_tag, result_ready,
        input  job_ready, result_valid, result_tag, result_count
    );

    // slave: the scheduler
    modport slave (
        input  job_valid, job_tag, result_ready,
        output job_ready, result_valid, result_tag, result_count
    );
endinterface

// File: rtl/solver_scheduler.sv
// Shares NUM_SOLVERS solver instances: loads a job's limbs into the lowest idle solver, starts it,
// and returns finished iteration counts through a round-robin arbiter.
// Latency: job handshake to start pulse = num_limbs+2 cycles; solver done to result_valid = 2 cycles.
// Backpressure: job_ready drops while loading or with no idle slot; result held stable while !result_ready.
//
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   cfg_*_i / cfg_busy_o         num_limbs / iteration limit write, ignored while busy or num_limbs==0
//   bus (slave)                  job and result valid/ready channels
//   load_done_o                  coordinate buffer may be overwritten
//   limb_rd_en_o/limb_rd_ind_o   coordinate buffer read, data valid next cycle
//   sol_wr_*_o                   limb write / config broadcast to solvers
//   sol_start_o                  one-hot start pulse
//   sol_out_ready_i/sol_iter_count_i   per-solver finish flag and iteration count
module solver_scheduler #(
    parameter int NUM_SOLVERS     = 4,
    parameter int LIMB_INDEX_BITS = 6,
    parameter int TAG_BITS        = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         cfg_wr_i,
    input  logic [LIMB_INDEX_BITS-1:0]   cfg_num_limbs_i,
    input  logic [15:0]                  cfg_iter_lim_i,
    output logic                         cfg_busy_o,
    solver_scheduler_if.slave            bus,
    output logic                         load_done_o,
    output logic                         limb_rd_en_o,
    output logic [LIMB_INDEX_BITS-1:0]   limb_rd_ind_o,
    output logic [LIMB_INDEX_BITS-1:0]   sol_wr_ind_o,
    output logic [NUM_SOLVERS-1:0]       sol_wr_en_o,
    output logic                         sol_wr_num_limbs_en_o,
    output logic                         sol_wr_iter_lim_en_o,
    output logic [LIMB_INDEX_BITS-1:0]   sol_num_limbs_o,
    output logic [15:0]                  sol_iter_lim_o,
    output logic [NUM_SOLVERS-1:0]       sol_start_o,
    input  logic [NUM_SOLVERS-1:0]       sol_out_ready_i,
    input  logic [16*NUM_SOLVERS-1:0]    sol_iter_count_i
);
    localparam int SLOT_W = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
    typedef logic [SLOT_W-1:0] slot_idx_t;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START} state_t;
    typedef enum logic [1:0] {SL_IDLE, SL_LOADING, SL_BUSY, SL_DONE} slot_t;

    state_t                      state_q, state_d;
    slot_t                       slot_q     [NUM_SOLVERS];
    slot_t                       slot_d     [NUM_SOLVERS];
    logic [TAG_BITS-1:0]         slot_tag_q [NUM_SOLVERS];
    logic [TAG_BITS-1:0]         slot_tag_d [NUM_SOLVERS];
    slot_idx_t                   slot_sel_q, slot_sel_d;
    logic [LIMB_INDEX_BITS-1:0]  rd_idx_q, rd_idx_d;
    logic [LIMB_INDEX_BITS-1:0]  wr_ind_q, wr_ind_d;
    logic [NUM_SOLVERS-1:0]      wr_en_q, wr_en_d;
    logic [NUM_SOLVERS-1:0]      start_q, start_d;
    logic                        load_done_q, load_done_d;
    logic [LIMB_INDEX_BITS-1:0]  num_limbs_q, num_limbs_d;
    logic [15:0]                 iter_lim_q, iter_lim_d;
    logic                        cfg_pulse_q, cfg_pulse_d;
    slot_idx_t                   rr_q, rr_d;
    logic                        res_vld_q, res_vld_d;
    logic [TAG_BITS-1:0]         res_tag_q, res_tag_d;
    logic [15:0]                 res_cnt_q, res_cnt_d;
    slot_idx_t                   res_slot_q, res_slot_d;

    logic                        any_idle, any_active;
    slot_idx_t                   idle_idx;
    logic [NUM_SOLVERS-1:0]      done_mask;
    logic                        cfg_accept, job_hs, res_hs;
    logic [NUM_SOLVERS-1:0]      sel_oh;
    slot_idx_t                   pick_ptr, pick_idx;
    logic [NUM_SOLVERS-1:0]      pick_req;
    logic                        pick_found;
    int                          pick_j;

    function automatic slot_idx_t next_slot(input slot_idx_t s);
        if (int'(s) >= NUM_SOLVERS - 1) return '0;
        return s + slot_idx_t'(1);
    endfunction

    // Slot summary; scanning downwards leaves the lowest idle index in idle_idx.
    always_comb begin
        any_idle   = 1'b0;
        any_active = 1'b0;
        idle_idx   = '0;
        done_mask  = '0;
        for (int i = NUM_SOLVERS - 1; i >= 0; i--) begin
            if (slot_q[i] == SL_IDLE) begin
                any_idle = 1'b1;
                idle_idx = slot_idx_t'(i);
            end else begin
                any_active = 1'b1;
            end
            done_mask[i] = (slot_q[i] == SL_DONE);
        end
    end

    assign cfg_busy_o    = (state_q != S_IDLE) || any_active;
    assign cfg_accept    = cfg_wr_i && !cfg_busy_o && (cfg_num_limbs_i != '0);
    assign bus.job_ready = !reset && (state_q == S_IDLE) && any_idle && !cfg_wr_i;
    assign job_hs        = bus.job_valid && bus.job_ready;
    assign res_hs        = res_vld_q && bus.result_ready;
    assign sel_oh        = NUM_SOLVERS'(1) << slot_sel_q;

    // Round-robin pick. On a handshake the departing winner is masked and the search starts
    // just past it, so the next result can be registered in the same cycle.
    always_comb begin
        pick_ptr   = res_hs ? next_slot(res_slot_q) : rr_q;
        pick_req   = done_mask;
        if (res_hs) pick_req[res_slot_q] = 1'b0;
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_j     = 0;
        for (int k = 0; k < NUM_SOLVERS; k++) begin
            pick_j = (int'(pick_ptr) + k) % NUM_SOLVERS;
            if (!pick_found && pick_req[pick_j]) begin
                pick_found = 1'b1;
                pick_idx   = slot_idx_t'(pick_j);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        slot_sel_d   = slot_sel_q;
        rd_idx_d     = rd_idx_q;
        wr_ind_d     = wr_ind_q;
        wr_en_d      = '0;
        start_d      = '0;
        load_done_d  = 1'b0;
        limb_rd_en_o = 1'b0;
        num_limbs_d  = num_limbs_q;
        iter_lim_d   = iter_lim_q;
        cfg_pulse_d  = 1'b0;
        rr_d         = rr_q;
        res_vld_d    = res_vld_q;
        res_tag_d    = res_tag_q;
        res_cnt_d    = res_cnt_q;
        res_slot_d   = res_slot_q;
        for (int i = 0; i < NUM_SOLVERS; i++) begin
            slot_d[i]     = slot_q[i];
            slot_tag_d[i] = slot_tag_q[i];
        end

        if (cfg_accept) begin
            num_limbs_d = cfg_num_limbs_i;
            iter_lim_d  = cfg_iter_lim_i;
            cfg_pulse_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (job_hs) begin
                    slot_sel_d           = idle_idx;
                    slot_d[idle_idx]     = SL_LOADING;
                    slot_tag_d[idle_idx] = bus.job_tag;
                    rd_idx_d             = '0;
                    state_d              = S_LOAD;
                end
            end
            S_LOAD: begin
                limb_rd_en_o = 1'b1;
                // Buffer data arrives next cycle, so the solver write trails the read by one.
                wr_en_d      = sel_oh;
                wr_ind_d     = rd_idx_q;
                if (rd_idx_q == num_limbs_q - 1'b1) state_d  = S_START;
                else                                 rd_idx_d = rd_idx_q + 1'b1;
            end
            S_START: begin
                load_done_d = 1'b1;
                start_d     = sel_oh;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A solver still shows out_ready from its previous job during the start cycle;
        // staying LOADING until then keeps that stale flag from being taken as done.
        for (int i = 0; i < NUM_SOLVERS; i++) begin
            if (slot_q[i] == SL_LOADING && start_q[i])      slot_d[i] = SL_BUSY;
            if (slot_q[i] == SL_BUSY && sol_out_ready_i[i]) slot_d[i] = SL_DONE;
            if (res_hs && res_slot_q == slot_idx_t'(i))     slot_d[i] = SL_IDLE;
        end

        if (res_hs) begin
            res_vld_d = 1'b0;
            rr_d      = next_slot(res_slot_q);
        end
        if ((!res_vld_q || res_hs) && pick_found) begin
            res_vld_d  = 1'b1;
            res_slot_d = pick_idx;
            res_tag_d  = slot_tag_q[pick_idx];
            res_cnt_d  = sol_iter_count_i[16*pick_idx +: 16];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            slot_sel_q  <= '0;
            rd_idx_q    <= '0;
            wr_ind_q    <= '0;
            wr_en_q     <= '0;
            start_q     <= '0;
            load_done_q <= 1'b0;
            num_limbs_q <= LIMB_INDEX_BITS'(1);
            iter_lim_q  <= '0;
            cfg_pulse_q <= 1'b0;
            rr_q        <= '0;
            res_vld_q   <= 1'b0;
            res_tag_q   <= '0;
            res_cnt_q   <= '0;
            res_slot_q  <= '0;
            for (int i = 0; i < NUM_SOLVERS; i++) begin
                slot_q[i]     <= SL_IDLE;
                slot_tag_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            slot_sel_q  <= slot_sel_d;
            rd_idx_q    <= rd_idx_d;
            wr_ind_q    <= wr_ind_d;
            wr_en_q     <= wr_en_d;
            start_q     <= start_d;
            load_done_q <= load_done_d;
            num_limbs_q <= num_limbs_d;
            iter_lim_q  <= iter_lim_d;
            cfg_pulse_q <= cfg_pulse_d;
            rr_q        <= rr_d;
            res_vld_q   <= res_vld_d;
            res_tag_q   <= res_tag_d;
            res_cnt_q   <= res_cnt_d;
            res_slot_q  <= res_slot_d;
            for (int i = 0; i < NUM_SOLVERS; i++) begin
                slot_q[i]     <= slot_d[i];
                slot_tag_q[i] <= slot_tag_d[i];
            end
        end
    end

    assign load_done_o           = load_done_q;
    assign limb_rd_ind_o         = rd_idx_q;
    assign sol_wr_ind_o          = wr_ind_q;
    assign sol_wr_en_o           = wr_en_q;
    assign sol_start_o           = start_q;
    assign sol_wr_num_limbs_en_o = cfg_pulse_q;
    assign sol_wr_iter_lim_en_o  = cfg_pulse_q;
    assign sol_num_limbs_o       = num_limbs_q;
    assign sol_iter_lim_o        = iter_lim_q;
    assign bus.result_valid      = res_vld_q;
    assign bus.result_tag        = res_tag_q;
    assign bus.result_count      = res_cnt_q;
endmodule

// File: tb/tb_solver_scheduler.sv
// Bench for solver_scheduler: load-timing vector table plus hand sequences for arbitration,
// backpressure, config gating and reset; results checked against a scoreboard queue.
module tb_solver_scheduler;
    logic        clock = 1'b0;
    logic        reset;
    logic        cfg_wr;
    logic [5:0]  cfg_num_limbs;
    logic [15:0] cfg_iter_lim;
    logic        cfg_busy;
    logic        load_done, limb_rd_en, nl_en, il_en;
    logic [5:0]  limb_rd_ind, sol_wr_ind, sol_num_limbs;
    logic [15:0] sol_iter_lim;
    logic [3:0]  sol_wr_en, sol_start, sol_out_ready;
    logic [63:0] sol_iter_count;

    always #5 clock = ~clock;

    solver_scheduler_if #(.TAG_BITS(16)) bus ();

    solver_scheduler #(.NUM_SOLVERS(4), .LIMB_INDEX_BITS(6), .TAG_BITS(16)) dut (
        .clock(clock), .reset(reset),
        .cfg_wr_i(cfg_wr), .cfg_num_limbs_i(cfg_num_limbs), .cfg_iter_lim_i(cfg_iter_lim),
        .cfg_busy_o(cfg_busy), .bus(bus),
        .load_done_o(load_done), .limb_rd_en_o(limb_rd_en), .limb_rd_ind_o(limb_rd_ind),
        .sol_wr_ind_o(sol_wr_ind), .sol_wr_en_o(sol_wr_en),
        .sol_wr_num_limbs_en_o(nl_en), .sol_wr_iter_lim_en_o(il_en),
        .sol_num_limbs_o(sol_num_limbs), .sol_iter_lim_o(sol_iter_lim),
        .sol_start_o(sol_start), .sol_out_ready_i(sol_out_ready), .sol_iter_count_i(sol_iter_count)
    );

    typedef struct { logic [15:0] tag; logic [15:0] cnt; } res_t;
    res_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Result monitor: pops the scoreboard on each handshake and checks stability under backpressure.
    logic        prev_hold = 1'b0;
    logic [15:0] prev_tag, prev_cnt;
    always @(negedge clock) begin
        if (bus.result_valid) begin
            if (prev_hold) begin
                check("hold_tag", {16'h0, bus.result_tag}, {16'h0, prev_tag});
                check("hold_cnt", {16'h0, bus.result_count}, {16'h0, prev_cnt});
            end
            if (bus.result_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: got tag %0h count %0h, none expected",
                             bus.result_tag, bus.result_count);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("result_tag", {16'h0, bus.result_tag}, {16'h0, e.tag});
                    check("result_count", {16'h0, bus.result_count}, {16'h0, e.cnt});
                end
                prev_hold = 1'b0;
            end else begin
                prev_hold = 1'b1;
                prev_tag  = bus.result_tag;
                prev_cnt  = bus.result_count;
            end
        end else begin
            if (prev_hold) check("hold_valid", {31'h0, bus.result_valid}, 32'h1);
            prev_hold = 1'b0;
        end
    end

    task automatic push_exp(input logic [15:0] tag, input logic [15:0] cnt);
        res_t r;
        r.tag = tag;
        r.cnt = cnt;
        exp_q.push_back(r);
    endtask

    // Starts and ends at posedge+1.
    task automatic cfg_write(input logic [5:0] num, input logic [15:0] lim, input logic exp_acc);
        cfg_wr = 1'b1; cfg_num_limbs = num; cfg_iter_lim = lim;
        @(negedge clock);
        check("cfg_blocks_job", {31'h0, bus.job_ready}, 32'h0);
        @(posedge clock); #1;
        cfg_wr = 1'b0;
        @(negedge clock);
        check("cfg_nl_en", {31'h0, nl_en}, {31'h0, exp_acc});
        check("cfg_il_en", {31'h0, il_en}, {31'h0, exp_acc});
        @(posedge clock); #1;
    endtask

    task automatic dispatch(input logic [15:0] tag, input int exp_slot, input int exp_lat);
        int k;
        int lat;
        bus.job_valid = 1'b1; bus.job_tag = tag;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!bus.job_ready && k < 40);
        if (!bus.job_ready) begin
            n_tests++; n_fail++;
            $display("FAIL dispatch_ready: job_ready never rose for tag %0h", tag);
            bus.job_valid = 1'b0;
            @(posedge clock); #1;
            return;
        end
        @(posedge clock); #1;
        bus.job_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (sol_start == 4'h0 && lat < 80);
        check("start_slot", {28'h0, sol_start}, 32'h1 << exp_slot);
        check("start_latency", lat, exp_lat);
        @(posedge clock); #1;
    endtask

    task automatic finish(input logic [3:0] mask, input logic [63:0] cnts);
        for (int i = 0; i < 4; i++) if (mask[i]) sol_iter_count[16*i +: 16] = cnts[16*i +: 16];
        sol_out_ready = mask;
        @(posedge clock); #1;
        sol_out_ready = 4'h0;
    endtask

    // Ends at negedge with result_valid seen (or a FAIL after the budget).
    task automatic wait_valid();
        int k;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!bus.result_valid && k < 30);
        check("result_valid_seen", {31'h0, bus.result_valid}, 32'h1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            @(posedge clock);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain: %0d results still outstanding", exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    typedef struct {
        logic        jv;
        logic [15:0] tag;
        logic        jr;
        logic        rd_en;
        logic [5:0]  rd_ind;
        logic [3:0]  wr_en;
        logic [5:0]  wr_ind;
        logic [3:0]  start;
        logic        ld;
    } vec_t;
    vec_t tbl[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Load of a 3-limb job into slot 0, cycle 0 = handshake.
        tbl[0] = '{1'b1, 16'h0012, 1'b1, 1'b0, 6'd0, 4'h0, 6'd0, 4'h0, 1'b0};
        tbl[1] = '{1'b0, 16'h0000, 1'b0, 1'b1, 6'd0, 4'h0, 6'd0, 4'h0, 1'b0};
        tbl[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 6'd1, 4'h1, 6'd0, 4'h0, 1'b0};
        tbl[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 6'd2, 4'h1, 6'd1, 4'h0, 1'b0};
        tbl[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 6'd2, 4'h1, 6'd2, 4'h0, 1'b0};
        tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 6'd2, 4'h0, 6'd0, 4'h1, 1'b1};
        tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 6'd2, 4'h0, 6'd0, 4'h0, 1'b0};

        reset = 1'b1; cfg_wr = 1'b0; cfg_num_limbs = 6'd0; cfg_iter_lim = 16'd0;
        bus.job_valid = 1'b0; bus.job_tag = 16'h0; bus.result_ready = 1'b1;
        sol_out_ready = 4'h0; sol_iter_count = 64'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_outputs", {load_done, limb_rd_en, limb_rd_ind, sol_wr_en, nl_en, sol_start,
                                bus.result_valid, bus.job_ready, cfg_busy}, 32'h0);
        check("reset_num_limbs", {26'h0, sol_num_limbs}, 32'd1);
        check("reset_iter_lim", {16'h0, sol_iter_lim}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("job_ready_after_reset", {31'h0, bus.job_ready}, 32'h1);
        @(posedge clock); #1;

        // Configuration, then verify the one-cycle broadcast pulse.
        cfg_write(6'd3, 16'd100, 1'b1);
        check("cfg_nl_en_one_cycle", {31'h0, nl_en}, 32'h0);
        check("cfg_num_limbs", {26'h0, sol_num_limbs}, 32'd3);
        check("cfg_iter_lim", {16'h0, sol_iter_lim}, 32'd100);

        // Load timing vectors.
        for (int i = 0; i < 7; i++) begin
            bus.job_valid = tbl[i].jv; bus.job_tag = tbl[i].tag;
            @(negedge clock);
            check($sformatf("vec%0d_job_ready", i), {31'h0, bus.job_ready}, {31'h0, tbl[i].jr});
            check($sformatf("vec%0d_rd_en", i), {31'h0, limb_rd_en}, {31'h0, tbl[i].rd_en});
            check($sformatf("vec%0d_rd_ind", i), {26'h0, limb_rd_ind}, {26'h0, tbl[i].rd_ind});
            check($sformatf("vec%0d_wr_en", i), {28'h0, sol_wr_en}, {28'h0, tbl[i].wr_en});
            if (tbl[i].wr_en != 4'h0)
                check($sformatf("vec%0d_wr_ind", i), {26'h0, sol_wr_ind}, {26'h0, tbl[i].wr_ind});
            check($sformatf("vec%0d_start", i), {28'h0, sol_start}, {28'h0, tbl[i].start});
            check($sformatf("vec%0d_load_done", i), {31'h0, load_done}, {31'h0, tbl[i].ld});
            @(posedge clock); #1;
        end

        // Single result held under backpressure for three cycles.
        bus.result_ready = 1'b0;
        push_exp(16'h0012, 16'd37);
        finish(4'b0001, {48'h0, 16'd37});
        wait_valid();
        repeat (3) begin @(posedge clock); #1; end
        bus.result_ready = 1'b1;
        drain();

        // num_limbs=0 is ignored; a following job still loads three limbs.
        cfg_write(6'd0, 16'd50, 1'b0);
        dispatch(16'h0034, 0, 5);
        @(negedge clock);
        check("cfg_busy_with_slot", {31'h0, cfg_busy}, 32'h1);
        @(posedge clock); #1;
        cfg_write(6'd2, 16'd9, 1'b0);
        check("cfg_ignored_iter_lim", {16'h0, sol_iter_lim}, 32'd100);

        // Fill remaining slots in lowest-index order.
        dispatch(16'h00A1, 1, 5);
        dispatch(16'h00A2, 2, 5);
        dispatch(16'h00A3, 3, 5);
        bus.job_valid = 1'b1; bus.job_tag = 16'h00EE;
        @(negedge clock);
        check("job_ready_all_busy", {31'h0, bus.job_ready}, 32'h0);
        @(posedge clock); #1;
        bus.job_valid = 1'b0;

        // Slot 1 finishes; a slot becomes dispatchable the cycle after its result is taken.
        bus.result_ready = 1'b0;
        push_exp(16'h00A1, 16'd11);
        finish(4'b0010, {32'h0, 16'd11, 16'h0});
        wait_valid();
        check("job_ready_result_pending", {31'h0, bus.job_ready}, 32'h0);
        @(posedge clock); #1;
        bus.result_ready = 1'b1;
        @(negedge clock);
        check("job_ready_at_handshake", {31'h0, bus.job_ready}, 32'h0);
        @(posedge clock); #1;
        @(negedge clock);
        check("job_ready_after_result", {31'h0, bus.job_ready}, 32'h1);
        @(posedge clock); #1;
        drain();

        // Slots 2 and 3 finish together with pointer at 2; 0xFFFF passes through.
        push_exp(16'h00A2, 16'd22);
        push_exp(16'h00A3, 16'hFFFF);
        finish(4'b1100, {16'hFFFF, 16'd22, 32'h0});
        drain();

        // Pointer wrapped to 0: slot 0 wins over slot 1.
        dispatch(16'h0055, 1, 5);
        push_exp(16'h0034, 16'd7);
        push_exp(16'h0055, 16'd8);
        finish(4'b0011, {32'h0, 16'd8, 16'd7});
        drain();

        // Reset in the middle of a load.
        bus.job_valid = 1'b1; bus.job_tag = 16'h0066;
        @(negedge clock);
        check("pre_reset_job_ready", {31'h0, bus.job_ready}, 32'h1);
        @(posedge clock); #1;
        bus.job_valid = 1'b0;
        @(negedge clock);
        check("mid_load_rd_en", {31'h0, limb_rd_en}, 32'h1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        check("mid_load_reset_outputs", {load_done, limb_rd_en, limb_rd_ind, sol_wr_en, sol_wr_ind,
                                         nl_en, sol_start, bus.result_valid, bus.job_ready,
                                         cfg_busy}, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("job_ready_after_mid_reset", {31'h0, bus.job_ready}, 32'h1);
        check("cfg_busy_after_mid_reset", {31'h0, cfg_busy}, 32'h0);
        @(posedge clock); #1;
        dispatch(16'h0077, 0, 3);
        push_exp(16'h0077, 16'h1234);
        finish(4'b0001, {48'h0, 16'h1234});
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
